// File: rtl/line_buffer_access_scheduler.sv
// line_buffer_access_scheduler: schedules one write slot per pixel and one 3x3-window read slot for a Sobel line buffer
module line_buffer_access_scheduler #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS = 480,
  parameter int P_BUFFER_ROWS = 4,
  parameter int P_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_ROW_BITS = $clog2(P_FRAME_ROWS),
  parameter int P_BUFFER_ROW_BITS = $clog2(P_BUFFER_ROWS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pixel_clk,
  input  logic data_valid,
  output logic write_enable,
  output logic [P_COLUMN_BITS-1:0] write_column,
  output logic [P_BUFFER_ROW_BITS-1:0] write_row,
  output logic read_enable,
  output logic [P_COLUMN_BITS-1:0] read_column,
  output logic [P_BUFFER_ROW_BITS-1:0] read_row,
  output logic [P_COLUMN_BITS-1:0] pixel_column,
  output logic [P_ROW_BITS-1:0] pixel_row,
  output logic matrix_ready,
  output logic frame_done,
  output logic overrun
);
  localparam int CW = $clog2(P_FRAME_COLUMNS + 1);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_HOLD} state_t;
  state_t state;
  logic [2:0] pclk_sync;
  logic [1:0] dv_sync;
  logic [CW-1:0] col;
  logic [P_ROW_BITS-1:0] row;
  logic [P_ROW_BITS-1:0] row_m1;
  logic line_active;
  logic pclk_rise;
  logic dv_s;
  logic window;
  assign pclk_rise = pclk_sync[1] & ~pclk_sync[2];
  assign dv_s = dv_sync[1];
  assign row_m1 = row - 1'b1;
  assign window = (col >= CW'(2)) && (row >= P_ROW_BITS'(2));
  // bring the pixel clock and data valid into clk; the extra pixel clock stage gives the rising-edge history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pclk_sync <= '0;
      dv_sync <= '0;
    end else begin
      pclk_sync <= {pclk_sync[1:0], pixel_clk};
      dv_sync <= {dv_sync[0], data_valid};
    end
  // slot sequencer: write, optional window read, read-latency hold, with registered strobes and coordinates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      col <= '0;
      row <= '0;
      line_active <= 1'b0;
      write_enable <= 1'b0;
      write_column <= '0;
      write_row <= '0;
      read_enable <= 1'b0;
      read_column <= '0;
      read_row <= '0;
      pixel_column <= '0;
      pixel_row <= '0;
      matrix_ready <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      read_enable <= 1'b0;
      matrix_ready <= 1'b0;
      frame_done <= 1'b0;
      if (pclk_rise && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE:
          if (pclk_rise) begin
            if (dv_s) begin
              if (col < CW'(P_FRAME_COLUMNS)) begin
                state <= S_WRITE;
                write_enable <= 1'b1;
                write_column <= col[P_COLUMN_BITS-1:0];
                write_row <= row[P_BUFFER_ROW_BITS-1:0];
              end else overrun <= 1'b1;
            end else if (line_active) begin
              col <= '0;
              line_active <= 1'b0;
              frame_done <= row == P_ROW_BITS'(P_FRAME_ROWS - 1);
              row <= row == P_ROW_BITS'(P_FRAME_ROWS - 1) ? '0 : row + 1'b1;
            end
          end
        S_WRITE: begin
          col <= col + 1'b1;
          line_active <= 1'b1;
          state <= window ? S_READ : S_IDLE;
          if (window) begin
            read_enable <= 1'b1;
            read_column <= write_column - 1'b1;
            read_row <= row_m1[P_BUFFER_ROW_BITS-1:0];
          end
        end
        S_READ: state <= S_HOLD;
        S_HOLD: begin
          state <= S_IDLE;
          matrix_ready <= 1'b1;
          pixel_column <= read_column;
          pixel_row <= row_m1;
        end
      endcase
    end
endmodule

// File: tb/tb_line_buffer_access_scheduler.sv
// tb_line_buffer_access_scheduler: slot-schedule model plus directed pixel streams for the line buffer scheduler
module tb_line_buffer_access_scheduler;
  localparam int C = 12;
  localparam int R = 7;
  localparam int B = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic pixel_clk = 0;
  logic data_valid = 0;
  logic write_enable;
  logic [3:0] write_column;
  logic [1:0] write_row;
  logic read_enable;
  logic [3:0] read_column;
  logic [1:0] read_row;
  logic [3:0] pixel_column;
  logic [2:0] pixel_row;
  logic matrix_ready;
  logic frame_done;
  logic overrun;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_we = 0, n_rd = 0, n_mr = 0, n_fd = 0;
  int m_col = 0, m_row = 0, m_free = 0, m_ovr = 32'h7fffffff;
  bit m_la = 0;
  int e_wc[int], e_wr[int], e_rc[int], e_rr[int], e_pc[int], e_pr[int];
  bit e_fd[int];
  int h_wc = 0, h_wr = 0, h_rc = 0, h_rr = 0, h_pc = 0, h_pr = 0;
  int base;

  line_buffer_access_scheduler #(.P_FRAME_COLUMNS(C), .P_FRAME_ROWS(R)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_clk(pixel_clk), .data_valid(data_valid),
    .write_enable(write_enable), .write_column(write_column), .write_row(write_row),
    .read_enable(read_enable), .read_column(read_column), .read_row(read_row),
    .pixel_column(pixel_column), .pixel_row(pixel_row), .matrix_ready(matrix_ready),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", n, cyc, a, e);
    end
  endtask

  task automatic check_zero(string n);
    chk({n, "_we"}, write_enable, 0);
    chk({n, "_wc"}, write_column, 0);
    chk({n, "_wr"}, write_row, 0);
    chk({n, "_re"}, read_enable, 0);
    chk({n, "_rc"}, read_column, 0);
    chk({n, "_rr"}, read_row, 0);
    chk({n, "_pc"}, pixel_column, 0);
    chk({n, "_pr"}, pixel_row, 0);
    chk({n, "_mr"}, matrix_ready, 0);
    chk({n, "_fd"}, frame_done, 0);
    chk({n, "_ovr"}, overrun, 0);
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_free = 0; m_ovr = 32'h7fffffff; m_la = 0;
    e_wc.delete(); e_wr.delete(); e_rc.delete(); e_rr.delete();
    e_pc.delete(); e_pr.delete(); e_fd.delete();
    h_wc = 0; h_wr = 0; h_rc = 0; h_rr = 0; h_pc = 0; h_pr = 0;
  endtask

  // a pixel rise first sampled at edge n0 is acted on at edge n0+2; the scheduler is busy until m_free
  task automatic model_rise(bit dv, int n0);
    int e2;
    e2 = n0 + 2;
    if (e2 < m_free || (dv && m_col == C)) begin
      if (e2 < m_ovr) m_ovr = e2;
    end else if (dv) begin
      e_wc[e2] = m_col;
      e_wr[e2] = m_row % B;
      if (m_col >= 2 && m_row >= 2) begin
        e_rc[e2 + 1] = m_col - 1;
        e_rr[e2 + 1] = (m_row - 1) % B;
        e_pc[e2 + 3] = m_col - 1;
        e_pr[e2 + 3] = m_row - 1;
        m_free = e2 + 4;
      end else m_free = e2 + 2;
      m_col++;
      m_la = 1;
    end else if (m_la) begin
      m_col = 0;
      m_la = 0;
      if (m_row == R - 1) begin
        m_row = 0;
        e_fd[e2] = 1;
      end else m_row++;
    end
  endtask

  task automatic start(bit dv);
    pixel_clk = 1;
    data_valid = dv;
    model_rise(dv, cyc + 1);
  endtask

  task automatic pix(bit dv, int hi, int lo);
    start(dv);
    repeat (hi) @(negedge clk);
    pixel_clk = 0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic line(int hi, int lo);
    for (int c = 0; c < C; c++) pix(1, hi, lo);
    pix(0, hi, lo);
  endtask

  task automatic probe(int wc, int wr, int rc, int rr, int pc, int pr);
    int n0;
    start(1);
    n0 = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 3) pixel_clk = 0;
      if (cyc == n0 + 2) begin
        chk("probe_we", write_enable, 1);
        chk("probe_wc", write_column, wc);
        chk("probe_wr", write_row, wr);
      end
      if (cyc == n0 + 3) begin
        chk("probe_re", read_enable, 1);
        chk("probe_rc", read_column, rc);
        chk("probe_rr", read_row, rr);
      end
      if (cyc == n0 + 5) begin
        chk("probe_mr", matrix_ready, 1);
        chk("probe_pc", pixel_column, pc);
        chk("probe_pr", pixel_row, pr);
      end
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (e_wc.exists(cyc)) begin h_wc = e_wc[cyc]; h_wr = e_wr[cyc]; end
      if (e_rc.exists(cyc)) begin h_rc = e_rc[cyc]; h_rr = e_rr[cyc]; end
      if (e_pc.exists(cyc)) begin h_pc = e_pc[cyc]; h_pr = e_pr[cyc]; end
      chk("write_enable", write_enable, int'(e_wc.exists(cyc)));
      chk("write_column", write_column, h_wc);
      chk("write_row", write_row, h_wr);
      chk("read_enable", read_enable, int'(e_rc.exists(cyc)));
      chk("read_column", read_column, h_rc);
      chk("read_row", read_row, h_rr);
      chk("matrix_ready", matrix_ready, int'(e_pc.exists(cyc)));
      chk("pixel_column", pixel_column, h_pc);
      chk("pixel_row", pixel_row, h_pr);
      chk("frame_done", frame_done, int'(e_fd.exists(cyc)));
      chk("overrun", overrun, int'(cyc >= m_ovr));
      n_we += int'(write_enable);
      n_rd += int'(read_enable);
      n_mr += int'(matrix_ready);
      n_fd += int'(frame_done);
    end

  initial begin
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst_n = 1;
    repeat (4) @(negedge clk);
    check_zero("idle");
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++)
        if (r == 2 && c == 2) probe(2, 2, 1, 1, 1, 1);
        else if (r == 5 && c == 10) probe(10, 1, 9, 0, 9, 4);
        else pix(1, 4, 4);
      pix(0, 4, 4);
      if (r == 0) begin
        chk("row0_writes", n_we, 12);
        chk("row0_reads", n_rd, 0);
        chk("row0_last_col", write_column, 11);
        chk("row0_wrow", write_row, 0);
      end
    end
    pix(0, 4, 4);
    pix(0, 4, 4);
    chk("frame_writes", n_we, 84);
    chk("frame_reads", n_rd, 50);
    chk("frame_ready", n_mr, 50);
    chk("frame_done_count", n_fd, 1);
    chk("frame_overrun", overrun, 0);
    line(4, 4);
    line(4, 4);
    pix(1, 4, 4);
    pix(1, 4, 4);
    start(1);
    repeat (4) @(negedge clk);
    pixel_clk = 0;
    #2;
    chk("pre_reset_read", read_enable, 1);
    rst_n = 0;
    model_reset();
    #1;
    check_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    base = n_we;
    pix(1, 4, 4);
    chk("post_reset_writes", n_we - base, 1);
    chk("post_reset_wcol", write_column, 0);
    chk("post_reset_wrow", write_row, 0);
    for (int c = 1; c < C; c++) pix(1, 4, 4);
    pix(0, 4, 4);
    line(4, 4);
    chk("pre_overrun", overrun, 0);
    repeat (6) pix(1, 2, 1);
    pix(0, 4, 4);
    chk("overrun_set", overrun, 1);
    pix(1, 4, 4);
    pix(0, 4, 4);
    repeat (4) @(negedge clk);
    chk("overrun_sticky", overrun, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
